// File: rtl/mem_sram_controller_if.sv
// Pipeline-side request/response bundle of the MEM-stage SRAM responder.
// The pipeline drives the request; the controller returns read data and ready.
interface mem_sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/mem_sram_controller.sv
// MEM-stage responder: splits each 32-bit load/store into two 16-bit accesses
// on an asynchronous SRAM and holds ready low while the access is in flight.
module mem_sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_sram_controller_if.slave bus,
  inout  wire  [15:0]          SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [31:0]        r_read_data;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic               r_we_n;
  logic [15:0]        r_dq_out;

  logic [31:0]        w_eff;
  logic [SRAM_AW-2:0] w_word;
  logic               w_req;
  logic               w_is_wr;
  logic               w_last;

  // A simultaneous read and write request is served as a read.
  assign w_eff   = bus.address - BASE_ADDR;
  assign w_word  = w_eff[SRAM_AW:2];
  assign w_req   = bus.rd_en | bus.wr_en;
  assign w_is_wr = bus.wr_en & ~bus.rd_en;
  assign w_last  = (r_cnt == LAST_CNT);

  // Access sequencer: address, strobe and outgoing data are all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_read_data <= 32'd0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_dq_out    <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 4'd0;
          if (w_req) begin
            r_state     <= LO;
            r_sram_addr <= {w_word, 1'b0};
            r_we_n      <= ~w_is_wr;
            r_dq_out    <= bus.write_data[15:0];
          end else begin
            r_we_n      <= 1'b1;
          end
        end
        LO: begin
          if (w_last) begin
            if (r_we_n) begin
              r_read_data[15:0] <= SRAM_DQ;
            end
            r_state     <= HI;
            r_cnt       <= 4'd0;
            r_sram_addr <= {w_word, 1'b1};
            r_dq_out    <= bus.write_data[31:16];
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        HI: begin
          if (w_last) begin
            if (r_we_n) begin
              r_read_data[31:16] <= SRAM_DQ;
            end
            r_state <= DONE;
            r_cnt   <= 4'd0;
            r_we_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_we_n  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
          r_we_n  <= 1'b1;
        end
      endcase
    end
  end

  // ready is combinational so an idle controller never stalls the pipeline.
  assign bus.ready     = ((r_state == IDLE) & ~w_req) | (r_state == DONE);
  assign bus.read_data = r_read_data;

  assign SRAM_DQ   = r_we_n ? 16'hzzzz : r_dq_out;
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_mem_sram_controller.sv
// Bench for mem_sram_controller: two instances (WAIT_CYCLES 2 and 1), each
// with a small SRAM model; read results are checked through a scoreboard.
module tb_mem_sram_controller;

  logic clk;
  logic rst;
  logic clr;
  logic sram_drive;

  int n_checks;
  int n_errors;

  mem_sram_controller_if b0 ();
  mem_sram_controller_if b1 ();

  wire  [15:0] dq0;
  wire  [15:0] dq1;
  logic [17:0] addr0;
  logic [17:0] addr1;
  logic        we0, oe0, ce0, ub0, lb0;
  logic        we1, oe1, ce1, ub1, lb1;

  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];
  logic [15:0] ref0 [0:255];
  logic [15:0] ref1 [0:255];
  logic [31:0] sb_q [$];

  mem_sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .SRAM_AW(18)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave),
    .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0),
    .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );

  mem_sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave),
    .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1),
    .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: drive the bus while not being written, capture on WE_N low.
  assign dq0 = (sram_drive && we0) ? mem0[addr0[7:0]] : 16'hzzzz;
  assign dq1 = (sram_drive && we1) ? mem1[addr1[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 16'h0000;
        mem1[i] <= 16'h0000;
      end
    end else begin
      if (!we0) mem0[addr0[7:0]] <= dq0;
      if (!we1) mem1[addr1[7:0]] <= dq1;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the selected DUT idle.
  task automatic run_access(input int sel, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input bit release_req);
    int          wc;
    int          last;
    logic [31:0] widx;
    logic [7:0]  hidx;
    logic [31:0] expv;
    logic [31:0] rdat;
    logic        rdy;
    logic        wen;
    logic        wexp;
    wc   = (sel == 0) ? 2 : 1;
    last = 2 * wc + 1;
    widx = (addr - 32'd1024) >> 2;
    hidx = {widx[6:0], 1'b0};
    if (sel == 0) begin
      b0.rd_en = rd; b0.wr_en = wr; b0.address = addr; b0.write_data = data;
    end else begin
      b1.rd_en = rd; b1.wr_en = wr; b1.address = addr; b1.write_data = data;
    end
    if (rd) begin
      if (sel == 0) sb_q.push_back({ref0[hidx + 8'd1], ref0[hidx]});
      else          sb_q.push_back({ref1[hidx + 8'd1], ref1[hidx]});
    end else if (wr) begin
      if (sel == 0) begin
        ref0[hidx] = data[15:0]; ref0[hidx + 8'd1] = data[31:16];
      end else begin
        ref1[hidx] = data[15:0]; ref1[hidx + 8'd1] = data[31:16];
      end
    end
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      rdy  = (sel == 0) ? b0.ready : b1.ready;
      wen  = (sel == 0) ? we0 : we1;
      rdat = (sel == 0) ? b0.read_data : b1.read_data;
      wexp = (wr && !rd && c >= 1 && c < last) ? 1'b0 : 1'b1;
      check_value("ready", {31'd0, rdy}, {31'd0, (c == last)});
      check_value("we_n", {31'd0, wen}, {31'd0, wexp});
      if (c == last && rd) begin
        expv = sb_q.pop_front();
        check_value("read_data", rdat, expv);
      end
    end
    @(posedge clk);
    #1;
    if (release_req) begin
      if (sel == 0) begin b0.rd_en = 1'b0; b0.wr_en = 1'b0; end
      else          begin b1.rd_en = 1'b0; b1.wr_en = 1'b0; end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) begin
      ref0[i] = 16'h0000;
      ref1[i] = 16'h0000;
    end
    rst = 1'b0; clr = 1'b1; sram_drive = 1'b0;
    b0.rd_en = 1'b0; b0.wr_en = 1'b0; b0.address = 32'd0; b0.write_data = 32'd0;
    b1.rd_en = 1'b0; b1.wr_en = 1'b0; b1.address = 32'd0; b1.write_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; clr = 1'b0;
    check_value("rst_read_data", b0.read_data, 32'd0);
    check_value("rst_sram_addr", {14'd0, addr0}, 32'd0);

    // Idle: ready high, no write strobe.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_value("idle_ready", {31'd0, b0.ready}, 32'd1);
      check_value("idle_we_n", {31'd0, we0}, 32'd1);
    end
    sram_drive = 1'b1;
    @(posedge clk);
    #1;

    run_access(0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b1);
    check_value("sram0_w0", {16'd0, mem0[0]}, 32'h5678);
    check_value("sram0_w1", {16'd0, mem0[1]}, 32'h1234);
    run_access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1);

    // Write then read with only the single IDLE gap in between.
    run_access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
    check_value("read_data_hold", b0.read_data, 32'h12345678);
    run_access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b1);
    check_value("sram0_w2", {16'd0, mem0[2]}, 32'hBEEF);
    check_value("sram0_w3", {16'd0, mem0[3]}, 32'hDEAD);

    run_access(0, 1'b1, 1'b0, 32'd1030, 32'd0, 1'b1);
    run_access(0, 1'b1, 1'b0, 32'd1024 + 32'h0008_0000, 32'd0, 1'b1);

    // Reset during the high half of a write.
    b0.wr_en = 1'b1; b0.address = 32'd1024; b0.write_data = 32'hAAAA5555;
    repeat (3) @(posedge clk);
    #1;
    check_value("hi_we_n", {31'd0, we0}, 32'd0);
    rst = 1'b0;
    b0.wr_en = 1'b0;
    #1;
    check_value("rst_mid_we_n", {31'd0, we0}, 32'd1);
    check_value("rst_mid_ready", {31'd0, b0.ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_value("partial_lo", {16'd0, mem0[0]}, 32'h5555);
    check_value("partial_hi", {16'd0, mem0[1]}, 32'h1234);
    ref0[0] = 16'h5555;
    run_access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1);

    // WAIT_CYCLES=1 instance: read+write together behaves as a read.
    run_access(1, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b1);
    run_access(1, 1'b1, 1'b1, 32'd1032, 32'h11112222, 1'b1);
    check_value("sram1_w4", {16'd0, mem1[4]}, 32'hF00D);
    check_value("sram1_w5", {16'd0, mem1[5]}, 32'hCAFE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
